sd_sector_reader: RTL and testbench

Read side of the SD-card write FIFO (`fifo_sd_card_write`). The block drains buffered bytes in whole sectors and streams each one to the SD card controller. Each sector is a byte-wide valid/ready stream framed by a start pulse and a done pulse, and carries an auto-incrementing sector address. A flush request lets a partial sector be written out, padded to full length.

---
 rtl/sd_sector_reader_if.sv | 29 ++
 rtl/sd_sector_reader.sv | 113 +++++++++++
 tb/tb_sd_sector_reader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_reader_if.sv
// Signal bundle linking the SD write-FIFO read port, the sector reader and
// the SD card controller's byte stream.
interface sd_sector_reader_if;
   logic [7:0]  fifo_dout_p;
   logic        fifo_empty_p;
   logic [12:0] fifo_data_count_p;
   logic        fifo_rd_en_p;
   logic        flush_p;
   logic        sd_busy_p;
   logic        sector_start_p;
   logic [31:0] sector_addr_p;
   logic [7:0]  sd_byte_p;
   logic        sd_byte_valid_p;
   logic        sd_byte_ready_p;
   logic        sector_done_p;
   logic [31:0] sectors_written_p;

   modport master (
      input  fifo_dout_p, fifo_empty_p, fifo_data_count_p, flush_p, sd_busy_p, sd_byte_ready_p,
      output fifo_rd_en_p, sector_start_p, sector_addr_p, sd_byte_p, sd_byte_valid_p,
             sector_done_p, sectors_written_p
   );

   modport slave (
      output fifo_dout_p, fifo_empty_p, fifo_data_count_p, flush_p, sd_busy_p, sd_byte_ready_p,
      input  fifo_rd_en_p, sector_start_p, sector_addr_p, sd_byte_p, sd_byte_valid_p,
             sector_done_p, sectors_written_p
   );
endinterface

// File: rtl/sd_sector_reader.sv
// Drains the SD write FIFO in whole sectors and streams each sector byte-wise
// to the SD controller; a flush writes out a partial sector padded to length.
module sd_sector_reader #(
   parameter int unsigned SECTOR_BYTES = 512,
   parameter logic [7:0]  PAD_BYTE     = 8'h00,
   parameter logic [31:0] START_ADDR   = 32'd0
) (
   input logic                clk210_p,
   input logic                reset_n_p,
   sd_sector_reader_if.master bus
);
   localparam int unsigned    CW   = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(SECTOR_BYTES - 1);
   localparam logic [12:0]    FULL = 13'(SECTOR_BYTES);

   typedef enum logic [2:0] {IDLE, ARM, RD, CAP, SEND, PAD, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          fl;
   logic          padded;
   logic [7:0]    hold;
   logic [31:0]   addr;
   logic [31:0]   written;

   assign bus.sector_addr_p     = addr;
   assign bus.sectors_written_p = written;

   always_comb begin
      state_nx            = state;
      bus.fifo_rd_en_p    = 1'b0;
      bus.sector_start_p  = 1'b0;
      bus.sd_byte_valid_p = 1'b0;
      bus.sector_done_p   = 1'b0;
      bus.sd_byte_p       = hold;
      case (state)
         IDLE: begin
            if (bus.fifo_data_count_p >= FULL ||
                ((bus.flush_p || fl) && !bus.fifo_empty_p))
               state_nx = ARM;
         end
         ARM: begin
            if (!bus.sd_busy_p) begin
               bus.sector_start_p = 1'b1;
               state_nx           = RD;
            end
         end
         RD: begin
            if (!bus.fifo_empty_p) begin
               bus.fifo_rd_en_p = 1'b1;
               state_nx         = CAP;
            end else if (fl) begin
               state_nx = PAD;
            end
         end
         CAP: state_nx = SEND;
         SEND: begin
            bus.sd_byte_valid_p = 1'b1;
            if (bus.sd_byte_ready_p)
               state_nx = (cnt == LAST) ? DONE : RD;
         end
         PAD: begin
            bus.sd_byte_valid_p = 1'b1;
            bus.sd_byte_p       = PAD_BYTE;
            if (bus.sd_byte_ready_p && cnt == LAST)
               state_nx = DONE;
         end
         DONE: begin
            bus.sector_done_p = 1'b1;
            state_nx          = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk210_p) begin
      if (!reset_n_p) begin
         state   <= IDLE;
         cnt     <= '0;
         fl      <= 1'b0;
         padded  <= 1'b0;
         hold    <= '0;
         addr    <= START_ADDR;
         written <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (bus.flush_p && !bus.fifo_empty_p) fl <= 1'b1;
            ARM: begin
               if (!bus.sd_busy_p) begin
                  cnt    <= '0;
                  padded <= 1'b0;
               end
            end
            CAP:  hold <= bus.fifo_dout_p;
            SEND: if (bus.sd_byte_ready_p) cnt <= cnt + 1'b1;
            PAD: begin
               padded <= 1'b1;
               if (bus.sd_byte_ready_p) cnt <= cnt + 1'b1;
            end
            DONE: begin
               addr    <= addr + 1'b1;
               written <= written + 1'b1;
               // keep a mid-sector flush alive so leftover bytes follow as a padded sector
               if (padded || bus.fifo_empty_p) fl <= 1'b0;
            end
            default: ;
         endcase
         if (bus.flush_p && state inside {ARM, RD, CAP, SEND, PAD})
            fl <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sd_sector_reader.sv
// Directed/randomized bench for sd_sector_reader: FIFO model, byte-stream
// monitor and a reference built from the pushed byte order plus padding.
`timescale 1ns/1ps
module tb_sd_sector_reader;
   localparam int unsigned SB    = 512;
   localparam logic [7:0]  PADB  = 8'hA5;
   localparam logic [31:0] START = 32'hFFFF_FFFF;

   logic clk210_p  = 1'b0;
   logic reset_n_p = 1'b0;
   always #5 clk210_p = ~clk210_p;

   sd_sector_reader_if bus ();

   sd_sector_reader #(
      .SECTOR_BYTES (SB),
      .PAD_BYTE     (PADB),
      .START_ADDR   (START)
   ) dut (
      .clk210_p  (clk210_p),
      .reset_n_p (reset_n_p),
      .bus       (bus)
   );

   // Byte source: src[rd_ptr..wr_ptr) is the FIFO content.
   logic [7:0]  src [0:16383];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   logic        fifo_clear = 1'b0;
   logic        rd_seen = 1'b0;

   always @(posedge clk210_p) begin
      if (fifo_clear) begin
         rd_ptr = wr_ptr;
      end else if (rd_seen && rd_ptr != wr_ptr) begin
         bus.fifo_dout_p <= src[rd_ptr];
         rd_ptr = rd_ptr + 1;
      end
      bus.fifo_empty_p      <= (rd_ptr == wr_ptr);
      bus.fifo_data_count_p <= 13'(wr_ptr - rd_ptr);
   end

   int unsigned rmode  = 0;
   int unsigned rphase = 0;
   always @(posedge clk210_p) begin
      #1;
      case (rmode)
         0: bus.sd_byte_ready_p = 1'b1;
         1: begin
            bus.sd_byte_ready_p = (rphase % 4 == 0) || (rphase % 4 == 3);
            rphase++;
         end
         default: bus.sd_byte_ready_p = 1'($urandom_range(0, 1));
      endcase
   end

   int unsigned cyc = 0, n_rd = 0, n_start = 0, n_done = 0, acc_n = 0;
   int unsigned stab_viol = 0, rd_empty_viol = 0, start_cyc = 0;
   logic [31:0] last_start_addr = '0;
   logic [7:0]  acc [0:16383];
   logic        pend_hold = 1'b0;
   logic [7:0]  held_byte = '0;

   always @(negedge clk210_p) begin
      if (!reset_n_p) begin
         pend_hold = 1'b0;
      end else begin
         if (bus.fifo_rd_en_p) begin
            n_rd++;
            if (bus.fifo_empty_p) rd_empty_viol++;
         end
         if (bus.sector_start_p) begin
            n_start++;
            last_start_addr = bus.sector_addr_p;
            start_cyc = cyc;
         end
         if (bus.sd_byte_valid_p) begin
            if (pend_hold && bus.sd_byte_p !== held_byte) stab_viol++;
            if (bus.sd_byte_ready_p === 1'b1) begin
               acc[acc_n] = bus.sd_byte_p;
               acc_n++;
               pend_hold = 1'b0;
            end else begin
               pend_hold = 1'b1;
               held_byte = bus.sd_byte_p;
            end
         end else if (pend_hold) begin
            stab_viol++;
            pend_hold = 1'b0;
         end
         if (bus.sector_done_p) n_done++;
      end
      rd_seen = reset_n_p && bus.fifo_rd_en_p;
      cyc++;
   end

   int unsigned checks = 0, errors = 0;
   int unsigned m_ptr = 0, acc_base = 0, rd_base = 0, exp_written = 0;
   logic [31:0] exp_addr = START;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk210_p);
      #1;
   endtask

   task automatic push(input int unsigned n, input bit counting, input logic [7:0] first);
      for (int unsigned i = 0; i < n; i++) begin
         src[wr_ptr] = counting ? 8'(first + 8'(i)) : 8'($urandom);
         wr_ptr++;
      end
   endtask

   task automatic wait_done(input int unsigned target, input string tag);
      int unsigned budget = 20000;
      while (n_done < target && budget > 0) begin
         tick(1);
         budget--;
      end
      chk({tag, "_done_count"}, n_done, target);
   endtask

   task automatic wait_bytes(input int unsigned n, input string tag);
      int unsigned budget = 10000;
      while (acc_n - acc_base < n && budget > 0) begin
         tick(1);
         budget--;
      end
      chk({tag, "_progress"}, 64'(acc_n - acc_base >= n), 64'd1);
   endtask

   // Expected sector: next n_real pushed bytes, then PADB up to the sector length.
   task automatic check_sector(input int unsigned n_real, input string tag);
      int unsigned mism = 0;
      logic [7:0]  e;
      for (int unsigned i = 0; i < SB; i++) begin
         e = (i < n_real) ? src[m_ptr + i] : PADB;
         if (acc[acc_base + i] !== e) mism++;
      end
      chk({tag, "_len"}, acc_n - acc_base, SB);
      chk({tag, "_data_mism"}, mism, 0);
      chk({tag, "_fifo_reads"}, n_rd - rd_base, n_real);
      chk({tag, "_start_addr"}, last_start_addr, exp_addr);
      exp_addr    = exp_addr + 1;
      exp_written = exp_written + 1;
      chk({tag, "_addr_after"}, bus.sector_addr_p, exp_addr);
      chk({tag, "_written"}, bus.sectors_written_p, exp_written);
      m_ptr    += n_real;
      acc_base  = acc_n;
      rd_base   = n_rd;
   endtask

   initial begin
      int unsigned k, n, c, st, dn;
      bus.flush_p         = 1'b0;
      bus.sd_busy_p       = 1'b0;
      bus.sd_byte_ready_p = 1'b1;
      tick(3);
      chk("rst_addr",    bus.sector_addr_p, START);
      chk("rst_written", bus.sectors_written_p, 0);
      chk("rst_valid",   bus.sd_byte_valid_p, 0);
      chk("rst_start",   bus.sector_start_p, 0);
      chk("rst_done",    bus.sector_done_p, 0);
      chk("rst_rd_en",   bus.fifo_rd_en_p, 0);
      chk("rst_byte",    bus.sd_byte_p, 0);
      reset_n_p = 1'b1;

      // Basic sector, counting bytes 1..512 (8-bit wrap).
      push(SB, 1'b1, 8'd1);
      wait_done(1, "basic");
      check_sector(SB, "basic");
      chk("basic_starts", n_start, 1);

      // Flush of a 15-byte partial sector; address wraps to 0.
      push(15, 1'b1, 8'd1);
      tick(3);
      bus.flush_p = 1'b1;
      tick(1);
      bus.flush_p = 1'b0;
      wait_done(2, "flush");
      check_sector(15, "flush");

      // Flush on an empty FIFO is ignored; padded sector cleared the latch.
      bus.flush_p = 1'b1;
      tick(2);
      bus.flush_p = 1'b0;
      tick(5);
      push(5, 1'b0, 8'd0);
      tick(60);
      chk("no_spurious_start", n_start, 2);

      // Mid-sector flush with leftovers and busy pulsing mid-sector.
      k = $urandom_range(1, 100);
      push(SB - 5 + k, 1'b0, 8'd0);
      wait_bytes(50, "midflush");
      bus.flush_p   = 1'b1;
      bus.sd_busy_p = 1'b1;
      tick(3);
      bus.flush_p   = 1'b0;
      bus.sd_busy_p = 1'b0;
      wait_done(3, "midflush_full");
      check_sector(SB, "midflush_full");
      wait_done(4, "midflush_tail");
      check_sector(k, "midflush_tail");

      // Backpressure with ready pattern 1,0,0,1.
      rmode = 1;
      push(SB, 1'b0, 8'd0);
      wait_done(5, "bp");
      check_sector(SB, "bp");
      chk("bp_stability", stab_viol, 0);

      // Random ready with a random-length flushed sector.
      rmode = 2;
      n = $urandom_range(1, SB - 1);
      push(n, 1'b0, 8'd0);
      tick(3);
      bus.flush_p = 1'b1;
      tick(1);
      bus.flush_p = 1'b0;
      wait_done(6, "rand_flush");
      check_sector(n, "rand_flush");
      rmode = 0;

      // Busy gating.
      bus.sd_busy_p = 1'b1;
      push(SB, 1'b0, 8'd0);
      tick(50);
      chk("busy_no_start", n_start, 6);
      chk("busy_no_read", n_rd - rd_base, 0);
      c = cyc;
      bus.sd_busy_p = 1'b0;
      tick(2);
      chk("busy_start_cycle", start_cyc, c);
      wait_done(7, "busy");
      check_sector(SB, "busy");

      // Reset mid-sector after 100 bytes.
      push(SB, 1'b0, 8'd0);
      wait_bytes(100, "reset");
      reset_n_p  = 1'b0;
      fifo_clear = 1'b1;
      tick(1);
      chk("mid_rst_addr",    bus.sector_addr_p, START);
      chk("mid_rst_written", bus.sectors_written_p, 0);
      chk("mid_rst_valid",   bus.sd_byte_valid_p, 0);
      chk("mid_rst_rd_en",   bus.fifo_rd_en_p, 0);
      chk("mid_rst_byte",    bus.sd_byte_p, 0);
      reset_n_p   = 1'b1;
      fifo_clear  = 1'b0;
      m_ptr       = wr_ptr;
      acc_base    = acc_n;
      rd_base     = n_rd;
      exp_addr    = START;
      exp_written = 0;
      st = n_start;
      dn = n_done;
      push(300, 1'b0, 8'd0);
      tick(60);
      chk("post_rst_partial_no_start", n_start, st);
      push(SB - 300, 1'b0, 8'd0);
      wait_done(dn + 1, "post_rst");
      check_sector(SB, "post_rst");

      chk("rd_while_empty", rd_empty_viol, 0);
      chk("stream_stability", stab_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
